// File: rtl/aes_job_scheduler.sv
// Purpose : shares one iterative AES-128 core between NUM_REQ requesters.
//           Each job is granted round-robin and its plaintext/key are latched.
//           The core is restarted, and its output is captured after AES_LATENCY cycles.
// Latency : accept edge E -> rsp_valid high after edge E+AES_LATENCY+1; jobs are at least AES_LATENCY+3 cycles apart.
// Backpressure: a stalled response (rsp_ready low) holds the block in RESP, and no new grants are issued.
// Ports   : clk/rst (sync, active-low); req_valid/req_ready/req_plaintext/req_key per requester (flat, 128b slices);
//           rsp_valid/rsp_ready/rsp_data/rsp_id response channel; aes_rst/aes_plaintext/aes_key/aes_out to the core;
//           busy is high whenever the FSM is not idle.
module aes_job_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int AES_LATENCY = 12,
  parameter int CNT_W       = 8,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_plaintext,
  input  logic [NUM_REQ*128-1:0] req_key,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [127:0]           rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   aes_rst,
  output logic [127:0]           aes_plaintext,
  output logic [127:0]           aes_key,
  input  logic [127:0]           aes_out,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [127:0]     rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [127:0]     pt_q, pt_d;
  logic [127:0]     key_q, key_d;

  logic             grant_vld;
  logic [ID_W-1:0]  grant_id;
  logic [127:0]     grant_pt;
  logic [127:0]     grant_key;
  int               idx;

  // Round-robin winner. The scan runs from the farthest offset down to rr_ptr itself,
  // so the last hit is the requester closest to rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  // Slice mux and one-hot ready. Grants are only ever visible in IDLE.
  always_comb begin
    grant_pt  = '0;
    grant_key = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        grant_pt  = req_plaintext[128*i +: 128];
        grant_key = req_key[128*i +: 128];
      end
      req_ready[i] = (state_q == S_IDLE) && grant_vld && (grant_id == ID_W'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    pt_d        = pt_q;
    key_d       = key_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          pt_d     = grant_pt;
          key_d    = grant_key;
          rsp_id_d = grant_id;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        // The core is still held in reset here, with its inputs already stable.
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(AES_LATENCY - 1)) begin
          rsp_data_d  = aes_out;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Start the next scan just after the requester that was served.
          rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      pt_q        <= '0;
      key_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      pt_q        <= pt_d;
      key_q       <= key_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_id        = rsp_id_q;
  assign aes_plaintext = pt_q;
  assign aes_key       = key_q;
  assign aes_rst       = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy          = (state_q != S_IDLE);

endmodule
